// File: rtl/vend_credit_seq.sv
// Vending transaction sequencer: owns the credit register and time-shares an external 5-bit add/sub unit.
// Optional macro VEND_AUTO_CHANGE_EN: when defined, leftover credit after a vend is paid out as change automatically.
module vend_credit_seq #(
  parameter logic [4:0] CHANGE_UNIT = 5'd5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       coin_valid,
  input  logic [4:0] coin_value,
  output logic       coin_ready,
  input  logic       buy_req,
  input  logic [4:0] price,
  input  logic       cancel,
  output logic [4:0] alu_a,
  output logic [4:0] alu_b,
  output logic       alu_sub,
  input  logic [4:0] alu_result,
  input  logic       alu_cb,
  output logic [4:0] credit,
  output logic       coin_reject,
  output logic       vend,
  output logic       insufficient,
  output logic       change_valid,
  output logic [4:0] change_coin,
  input  logic       change_ack,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CHECK  = 2'd1,
    S_CHANGE = 2'd2
  } state_t;

  state_t     r_state;
  logic [4:0] r_credit;
  logic [4:0] r_price;
  logic       r_vend;
  logic       r_insufficient;
  logic       r_coin_reject;
  logic       w_change_valid;

  // Operand selection depends only on state and stored registers, never on the unit's outputs.
  always_comb begin
    alu_a   = r_credit;
    alu_b   = 5'd0;
    alu_sub = 1'b0;
    case (r_state)
      S_IDLE: begin
        alu_b   = coin_value;
        alu_sub = 1'b0;
      end
      S_CHECK: begin
        alu_b   = r_price;
        alu_sub = 1'b1;
      end
      S_CHANGE: begin
        alu_b   = CHANGE_UNIT;
        alu_sub = 1'b1;
      end
      default: begin
        alu_b   = 5'd0;
        alu_sub = 1'b0;
      end
    endcase
  end

  assign w_change_valid = (r_state == S_CHANGE) && (r_credit != 5'd0);

  // A borrow on credit - CHANGE_UNIT means only a partial coin remains, so offer the remainder.
  always_comb begin
    if (w_change_valid) begin
      change_coin = alu_cb ? CHANGE_UNIT : r_credit;
    end else begin
      change_coin = 5'd0;
    end
  end

  // Transaction state machine with credit, latched price and registered status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_credit       <= 5'd0;
      r_price        <= 5'd0;
      r_vend         <= 1'b0;
      r_insufficient <= 1'b0;
      r_coin_reject  <= 1'b0;
    end else begin
      r_vend         <= 1'b0;
      r_insufficient <= 1'b0;
      r_coin_reject  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cancel) begin
            if (r_credit != 5'd0) begin
              r_state <= S_CHANGE;
            end else begin
              r_state <= S_IDLE;
            end
          end else if (buy_req) begin
            r_price <= price;
            r_state <= S_CHECK;
          end else if (coin_valid) begin
            if (alu_cb) begin
              r_coin_reject <= 1'b1;
            end else begin
              r_credit <= alu_result;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_CHECK: begin
          if (alu_cb) begin
            r_credit <= alu_result;
            r_vend   <= 1'b1;
`ifdef VEND_AUTO_CHANGE_EN
            r_state  <= (alu_result != 5'd0) ? S_CHANGE : S_IDLE;
`else
            r_state  <= S_IDLE;
`endif
          end else begin
            r_insufficient <= 1'b1;
            r_state        <= S_IDLE;
          end
        end
        S_CHANGE: begin
          if (r_credit == 5'd0) begin
            r_state <= S_IDLE;
          end else if (change_ack) begin
            if (alu_cb) begin
              r_credit <= alu_result;
              r_state  <= (alu_result == 5'd0) ? S_IDLE : S_CHANGE;
            end else begin
              r_credit <= 5'd0;
              r_state  <= S_IDLE;
            end
          end else begin
            r_state <= S_CHANGE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign coin_ready   = (r_state == S_IDLE) && !cancel && !buy_req;
  assign credit       = r_credit;
  assign vend         = r_vend;
  assign insufficient = r_insufficient;
  assign coin_reject  = r_coin_reject;
  assign change_valid = w_change_valid;
  assign busy         = (r_state != S_IDLE);

endmodule

// File: doc/vend_credit_seq.md
Name: vend_credit_seq

Overview:
Transaction sequencer for the vending datapath. It owns the 5-bit credit register and time-shares the external combinational 5-bit add/subtract unit. It drives that unit's a, b and sub inputs and consumes its result and carry_borrow outputs. It accumulates coins, checks and deducts the price on a purchase, and pays out change coin-by-coin over a valid/ack handshake.

Parameters:
CHANGE_UNIT, 5, denomination of a change coin (1..31).

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
coin_valid  in  1  coin inserted this cycle
coin_value  in  5  value of inserted coin
coin_ready  out  1  IDLE & !cancel & !buy_req (combinational)
buy_req  in  1  purchase request, one cycle
price  in  5  item price, sampled with buy_req
cancel  in  1  return all credit
alu_a  out  5  add/sub unit operand a
alu_b  out  5  add/sub unit operand b
alu_sub  out  1  add/sub unit mode: 1 = a-b, 0 = a+b
alu_result  in  5  add/sub unit result (same cycle)
alu_cb  in  1  add/sub unit carry_borrow: add -> 1 = overflow; sub -> 1 = no borrow (a>=b)
credit  out  5  current credit register
coin_reject  out  1  one-cycle pulse, coin refused (overflow)
vend  out  1  one-cycle pulse, item dispensed
insufficient  out  1  one-cycle pulse, price > credit
change_valid  out  1  change coin offered
change_coin  out  5  value of offered coin
change_ack  in  1  change coin taken
busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst_n=0): state IDLE, credit=0, price_q=0; vend, insufficient, coin_reject, change_valid, busy all 0; change_coin=0. Reset mid-transaction aborts immediately and pays no change.
- ALU is purely combinational. alu_a, alu_b and alu_sub decode from state and registers only, never from alu_* inputs. The result is registered on the next clk edge.
- States: IDLE, CHECK, CHANGE.
- IDLE: alu_a=credit, alu_b=coin_value, alu_sub=0. Priority is cancel > buy_req > coin_valid.
  - cancel: go to CHANGE if credit!=0, else stay in IDLE with no response.
  - buy_req: price_q<=price, go to CHECK; a coin in the same cycle is ignored.
  - coin_valid, alu_cb=0: credit<=alu_result.
  - coin_valid, alu_cb=1: credit unchanged, coin_reject=1 next cycle.
  - Coin accept is single-cycle and back-to-back coins are allowed.
- CHECK (one cycle): alu_a=credit, alu_b=price_q, alu_sub=1.
  - alu_cb=1: credit<=alu_result, vend=1 next cycle, go to CHANGE if alu_result!=0, else IDLE.
  - alu_cb=0: insufficient=1 next cycle, credit unchanged, go to IDLE.
  - price 0 vends with credit unchanged.
- CHANGE: alu_a=credit, alu_b=CHANGE_UNIT, alu_sub=1.
  - change_valid=(credit!=0).
  - change_coin = alu_cb ? CHANGE_UNIT : credit, so a final partial coin pays the remainder.
  - On change_ack & change_valid: credit <= alu_cb ? alu_result : 0. If the new credit is 0, go to IDLE.
  - change_valid and change_coin stay stable while ack is low. cancel, buy_req and coins are ignored in CHANGE.
  - Ack while change_valid=0 is ignored. Entering CHANGE with credit 0 returns to IDLE next cycle.
- Latency:
  - coin -> credit: 1 cycle.
  - buy_req -> vend or insufficient pulse: 2 cycles.
  - First change_valid: the cycle after vend is registered.
- Width: all arithmetic is 5-bit via the external unit; credit never exceeds 31.

Optional Feature:
VEND_AUTO_CHANGE_EN
- Defined: after a successful vend with nonzero remaining credit, CHECK goes to CHANGE as above.
- Undefined: CHECK always returns to IDLE after vend, and remaining credit is retained for further purchases. Change is paid only through cancel.

Test Plan (CHANGE_UNIT=5, VEND_AUTO_CHANGE_EN defined unless noted):
- Coins 10, 10 back-to-back -> credit 10 then 20. Coin 15 -> alu_cb=1, coin_reject pulse, credit stays 20.
- Credit 20, buy_req price 13 -> vend pulse, credit 7. Then change_coin 5, ack -> credit 2; change_coin 2, ack -> credit 0, IDLE, busy 0.
- Credit 7, buy_req price 9 -> insufficient pulse, no vend, credit 7, IDLE after 2 cycles.
- Credit 12, cancel, change_ack held low 3 cycles -> change_valid=1 with change_coin=5 stable. Then acks yield 5, 5, 2 and credit 0.
- rst_n low mid-CHANGE with credit 8 -> credit, change_valid and busy are 0 immediately, before the next clk edge.
- coin_valid (value 5) with buy_req (price 0) in IDLE, credit 3 -> coin ignored, vend pulse, credit 3. Same case with VEND_AUTO_CHANGE_EN undefined -> IDLE with credit 3.
